// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR word controller: state width, the
// reset/zero-recovery value, the controller FSM encoding and the step function.
package lfsr_pkg;

    localparam int LFSR_W = 26;
    localparam logic [LFSR_W-1:0] LFSR_ONE = 26'h0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } ctrl_state_t;

    // Galois x^26+x^8+x^7+x+1. Bit q_i of the [1:26] view lives at index 26-i,
    // so q26 (feedback) is bit 0 and the taps land on bits 24, 18 and 17.
    function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] n;
        logic fb;
        fb       = s[0];
        n[25]    = fb;
        n[24]    = s[25] ^ fb;
        n[23:19] = s[24:20];
        n[18]    = s[19] ^ fb;
        n[17]    = s[18] ^ fb;
        n[16:0]  = s[17:1];
        if (s == '0) begin
            n = LFSR_ONE;
        end
        return n;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// 26-bit LFSR state register: synchronous reset to one, seed load with
// zero-seed mapping, and single-step advance with all-zero recovery.
module lfsr_core
    import lfsr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              adv,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LFSR_ONE;
        end else if (load) begin
            // A zero seed would lock the register, so it is mapped to one.
            state <= (load_val == '0) ? LFSR_ONE : load_val;
        end else if (adv) begin
            state <= lfsr_advance(state);
        end
    end

    assign q = state;

endmodule

// File: rtl/lfsr_ctrl.sv
// LFSR word server: two requesters arbitrated round-robin, each grant delivers
// the LFSR state after STEPS advances. Optional word counter: LFSR_CTRL_WORD_CNT_EN.
module lfsr_ctrl
    import lfsr_pkg::*;
#(
    parameter int STEPS = 26,
    parameter int NREQ  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_vld,
    output logic              seed_rdy,
    input  logic [LFSR_W-1:0] seed,
    input  logic [NREQ-1:0]   req,
    output logic [NREQ-1:0]   gnt,
    output logic [LFSR_W-1:0] dout,
    output logic              dout_vld,
    output logic              busy,
    output logic [15:0]       word_cnt,
    output logic [1:0]        fsm_state
);

    localparam logic [5:0] STEPS_C = 6'(STEPS);

    ctrl_state_t       state, state_nxt;
    logic [5:0]        step_cnt;
    logic              winner;
    logic              win_nxt;
    logic              rr_ptr;
    logic [LFSR_W-1:0] seed_q;
    logic [LFSR_W-1:0] dout_q;
    logic [LFSR_W-1:0] lfsr_q;
    logic              seed_take;
    logic              run_start;
    logic              core_load;
    logic              core_adv;

    // Seed handshake: a seed transfers on a cycle where seed_vld && seed_rdy
    // at the rising edge; seed_rdy is high only in IDLE, nothing is queued.
    assign seed_rdy  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

    // On a tie the requester that was not granted last wins.
    assign win_nxt = (req == 2'b11) ? ~rr_ptr : req[1];

    always_comb begin
        state_nxt = state;
        seed_take = 1'b0;
        run_start = 1'b0;
        core_load = 1'b0;
        core_adv  = 1'b0;
        dout_vld  = 1'b0;
        gnt       = '0;
        case (state)
            ST_IDLE: begin
                if (seed_vld) begin
                    seed_take = 1'b1;
                    state_nxt = ST_LOAD;
                end else if (|req) begin
                    run_start = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_LOAD: begin
                core_load = 1'b1;
                state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                core_adv = 1'b1;
                if (step_cnt <= 6'd1) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                dout_vld    = 1'b1;
                gnt[winner] = 1'b1;
                state_nxt   = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            step_cnt <= 6'd0;
            winner   <= 1'b0;
            rr_ptr   <= 1'b1;
            seed_q   <= '0;
            dout_q   <= '0;
        end else begin
            state <= state_nxt;
            if (seed_take) begin
                seed_q <= seed;
            end
            if (run_start) begin
                winner   <= win_nxt;
                step_cnt <= STEPS_C;
            end else if (core_adv) begin
                step_cnt <= step_cnt - 6'd1;
            end
            if (dout_vld) begin
                rr_ptr <= winner;
                dout_q <= lfsr_q;
            end
        end
    end

    // The LFSR does not move in DONE, so the live state is the delivered word.
    assign dout = dout_vld ? lfsr_q : dout_q;

    lfsr_core u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (core_load),
        .load_val (seed_q),
        .adv      (core_adv),
        .q        (lfsr_q)
    );

`ifdef LFSR_CTRL_WORD_CNT_EN
    logic [15:0] word_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q <= 16'd0;
        end else if (dout_vld) begin
            word_cnt_q <= word_cnt_q + 16'd1;
        end
    end

    assign word_cnt = word_cnt_q;
`else
    assign word_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Directed bench for lfsr_ctrl: one instance with STEPS=1, one with STEPS=4,
// expected LFSR words computed by hand from x^26+x^8+x^7+x+1.
module tb_lfsr_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

`ifdef LFSR_CTRL_WORD_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        a_rst, a_seed_vld, a_seed_rdy, a_dout_vld, a_busy;
    logic [25:0] a_seed, a_dout;
    logic [1:0]  a_req, a_gnt, a_fsm;
    logic [15:0] a_word_cnt;

    logic        b_rst, b_seed_vld, b_seed_rdy, b_dout_vld, b_busy;
    logic [25:0] b_seed, b_dout;
    logic [1:0]  b_req, b_gnt, b_fsm;
    logic [15:0] b_word_cnt;

    lfsr_ctrl #(.STEPS(1), .NREQ(2)) u_a (
        .clk(clk), .rst(a_rst), .seed_vld(a_seed_vld), .seed_rdy(a_seed_rdy),
        .seed(a_seed), .req(a_req), .gnt(a_gnt), .dout(a_dout),
        .dout_vld(a_dout_vld), .busy(a_busy), .word_cnt(a_word_cnt),
        .fsm_state(a_fsm)
    );

    lfsr_ctrl #(.STEPS(4), .NREQ(2)) u_b (
        .clk(clk), .rst(b_rst), .seed_vld(b_seed_vld), .seed_rdy(b_seed_rdy),
        .seed(b_seed), .req(b_req), .gnt(b_gnt), .dout(b_dout),
        .dout_vld(b_dout_vld), .busy(b_busy), .word_cnt(b_word_cnt),
        .fsm_state(b_fsm)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wc(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    logic [1:0]  tie_gnt [4];
    logic [25:0] tie_dout[4];

    initial begin
        a_rst = 1'b1; a_seed_vld = 1'b0; a_seed = '0; a_req = 2'b00;
        b_rst = 1'b1; b_seed_vld = 1'b0; b_seed = '0; b_req = 2'b00;
        tie_gnt  = '{2'b01, 2'b10, 2'b01, 2'b10};
        tie_dout = '{26'h3060000, 26'h1830000, 26'h0C18000, 26'h060C000};

        // ---- instance A, STEPS=1 ----
        tick();
        chk("a_rst_gnt", a_gnt, 0);
        chk("a_rst_dout", a_dout, 0);
        chk("a_rst_vld", a_dout_vld, 0);
        chk("a_rst_busy", a_busy, 0);
        chk("a_rst_seed_rdy", a_seed_rdy, 1);
        chk("a_rst_wcnt", a_word_cnt, 0);
        chk("a_rst_fsm", a_fsm, 0);
        a_rst = 1'b0;
        a_req = 2'b01;
        tick();
        chk("a_t1_run_busy", a_busy, 1);
        chk("a_t1_run_gnt", a_gnt, 0);
        chk("a_t1_run_seed_rdy", a_seed_rdy, 0);
        tick();
        chk("a_t1_gnt", a_gnt, 2'b01);
        chk("a_t1_dout", a_dout, 26'h3060000);
        chk("a_t1_vld", a_dout_vld, 1);
        a_req = 2'b00;
        tick();
        chk("a_t1_idle_gnt", a_gnt, 0);
        chk("a_t1_idle_vld", a_dout_vld, 0);
        chk("a_t1_dout_hold", a_dout, 26'h3060000);
        chk("a_t1_idle_busy", a_busy, 0);

        // zero seed must be loaded as one
        chk("a_t2_seed_rdy", a_seed_rdy, 1);
        a_seed_vld = 1'b1;
        a_seed     = 26'h0;
        tick();
        chk("a_t2_load_busy", a_busy, 1);
        chk("a_t2_load_rdy", a_seed_rdy, 0);
        chk("a_t2_load_vld", a_dout_vld, 0);
        a_seed_vld = 1'b0;
        tick();
        a_req = 2'b10;
        tick();
        tick();
        chk("a_t2_gnt", a_gnt, 2'b10);
        chk("a_t2_dout", a_dout, 26'h3060000);
        a_req = 2'b00;
        tick();

        // reset, then both requesters held: grants alternate starting with req[0]
        a_rst = 1'b1;
        tick();
        chk("a_t3_rst_dout", a_dout, 0);
        chk("a_t3_rst_wcnt", a_word_cnt, 0);
        chk("a_t3_rst_busy", a_busy, 0);
        a_rst = 1'b0;
        a_req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            tick();
            chk("a_t3_run_gnt", a_gnt, 0);
            tick();
            chk($sformatf("a_t3_gnt%0d", g), a_gnt, tie_gnt[g]);
            chk($sformatf("a_t3_dout%0d", g), a_dout, tie_dout[g]);
            if (g == 3) a_req = 2'b00;
            tick();
            chk("a_t3_idle_gnt", a_gnt, 0);
        end
        chk("a_t3_wcnt", a_word_cnt, wc(4));

        // seed and request together: load wins, grant follows from new seed
        a_seed_vld = 1'b1;
        a_seed     = 26'h0000003;
        a_req      = 2'b01;
        tick();
        chk("a_t4_load_fsm", a_fsm, 1);
        chk("a_t4_load_gnt", a_gnt, 0);
        a_seed_vld = 1'b0;
        tick();
        chk("a_t4_idle_busy", a_busy, 0);
        tick();
        chk("a_t4_run_rdy", a_seed_rdy, 0);
        a_seed_vld = 1'b1;
        a_seed     = 26'h1234567;
        tick();
        chk("a_t4_gnt", a_gnt, 2'b01);
        chk("a_t4_dout", a_dout, 26'h3060001);
        a_seed_vld = 1'b0;
        a_req      = 2'b00;
        tick();
        chk("a_t4_no_queue_busy", a_busy, 0);
        chk("a_t4_dout_hold", a_dout, 26'h3060001);
        chk("a_t4_wcnt", a_word_cnt, wc(5));
        a_req = 2'b10;
        tick();
        tick();
        chk("a_t5_gnt", a_gnt, 2'b10);
        chk("a_t5_dout", a_dout, 26'h2850000);
        a_req = 2'b00;
        tick();
        chk("a_t5_wcnt", a_word_cnt, wc(6));

        // ---- instance B, STEPS=4 ----
        chk("b_rst_busy", b_busy, 0);
        chk("b_rst_dout", b_dout, 0);
        chk("b_rst_seed_rdy", b_seed_rdy, 1);
        chk("b_rst_fsm", b_fsm, 0);
        b_rst = 1'b0;
        b_req = 2'b01;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("b_t1_run%0d_gnt", c), b_gnt, 0);
            chk($sformatf("b_t1_run%0d_busy", c), b_busy, 1);
        end
        tick();
        chk("b_t1_gnt", b_gnt, 2'b01);
        chk("b_t1_dout", b_dout, 26'h060C000);
        chk("b_t1_vld", b_dout_vld, 1);
        b_req = 2'b10;
        tick();
        tick();
        tick();
        tick();
        chk("b_t2_run3_busy", b_busy, 1);
        b_rst = 1'b1;
        tick();
        chk("b_t2_abort_busy", b_busy, 0);
        chk("b_t2_abort_gnt", b_gnt, 0);
        chk("b_t2_abort_vld", b_dout_vld, 0);
        chk("b_t2_abort_dout", b_dout, 0);
        b_rst = 1'b0;
        b_req = 2'b01;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("b_t3_run%0d_gnt", c), b_gnt, 0);
        end
        tick();
        chk("b_t3_gnt", b_gnt, 2'b01);
        chk("b_t3_dout", b_dout, 26'h060C000);
        b_req = 2'b00;
        tick();
        chk("b_t3_wcnt", b_word_cnt, wc(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lfsr_ctrl.md
LFSR_CTRL -- requirements
Module: lfsr_ctrl

Interface
REQ-001 Parameter: STEPS, 26, LFSR advances per delivered word (1..63).
REQ-002 Parameter: NREQ, 2, number of requesters (fixed at 2 in this revision).
REQ-003 Port: clk  in  1  single clock, all logic on posedge; one clock, reset is synchronous and active-high.
REQ-004 Port: rst  in  1  synchronous active-high reset.
REQ-005 Port: seed_vld  in  1  seed offered; seed_rdy  out  1  seed acceptable (high only in IDLE).
REQ-006 Port: seed  in  26  seed value, bit order [1:26] (bit 1 = MSB of the literal).
REQ-007 Port: req  in  2  per-requester word request, level, held until grant.
REQ-008 Port: gnt  out  2  one-hot one-cycle grant pulse, coincident with dout_vld.
REQ-009 Port: dout  out  26  delivered LFSR state; dout_vld  out  1  dout valid pulse.
REQ-010 Port: busy  out  1  high when FSM is not IDLE.
REQ-011 Port: word_cnt  out  16  delivered-word count (see Configuration).

Function
REQ-012 LFSR state is 26 bits [1:26], Galois form, x^26+x^8+x^7+x+1: next q1=q26, q2=q1^q26, q3..7=q2..6, q8=q7^q26, q9=q8^q26, q10..26=q9..25.
REQ-013 If the state is ever all-zero, the next advance writes 26'h0000001 instead of the shift.
REQ-014 FSM states IDLE, LOAD, RUN, DONE; one-hot or binary at implementer's choice.
REQ-015 IDLE: seed_vld&&seed_rdy -> LOAD; else any req -> latch round-robin winner, -> RUN; else stay.
REQ-016 Seed acceptance has priority over requests in the same cycle.
REQ-017 LOAD (1 cycle): state <= seed, or 26'h0000001 if seed==0; -> IDLE; no grant.
REQ-018 RUN: advance LFSR once per cycle for exactly STEPS cycles (6-bit down-counter), then -> DONE.
REQ-019 DONE (1 cycle): dout=current state, dout_vld=1, gnt[winner]=1; -> IDLE.
REQ-020 Latency: req sampled in IDLE at cycle 0 -> gnt/dout_vld at cycle STEPS+1; minimum request-to-request spacing STEPS+2.
REQ-021 Arbitration: round-robin; pointer = last granted index; on tie the other requester wins; pointer updates at DONE.
REQ-022 Winner is fixed at RUN entry; req dropping during RUN does not cancel; gnt still pulses.
REQ-023 seed_vld outside IDLE is ignored (seed_rdy=0); no seed is queued.
REQ-024 dout holds its last value between pulses; gnt and dout_vld are zero outside DONE.

Reset
REQ-025 rst: FSM=IDLE, state=26'h0000001, dout=0, gnt=0, dout_vld=0, busy=0, rr pointer=1 (req[0] wins first tie), step counter=0, word_cnt=0.
REQ-026 rst mid-RUN or mid-LOAD aborts without grant; rst has priority over every other input.

Configuration
REQ-027 Macro LFSR_CTRL_WORD_CNT_EN: defined -> word_cnt increments by 1 on each dout_vld, wraps 16'hFFFF->0; undefined -> word_cnt tied 0, no counter flops.

Structure
REQ-028 Shared package lfsr_pkg: LFSR width constant (26), reset/zero-recovery constant 26'h0000001, FSM state enum.
REQ-029 One sub-module lfsr_core: 26-bit state register with load, advance and zero recovery per REQ-012/013; lfsr_ctrl instantiates it once.

Verification
REQ-030 STEPS=1, rst, then req=2'b01 -> gnt=2'b01 and dout=26'h3060000 at cycle 2.
REQ-031 STEPS=1, seed 26'h0 loaded, then req[1] -> dout=26'h3060000 (zero seed mapped to 1).
REQ-032 req=2'b11 held continuously -> grants alternate 01,10,01,10; first is 01 after reset.
REQ-033 seed_vld and req same IDLE cycle -> LOAD first, grant follows from the new seed; seed_vld during RUN -> seed_rdy=0, state unaffected.
REQ-034 rst asserted in 3rd RUN cycle -> no gnt, busy=0 next cycle, next grant starts from 26'h0000001.
REQ-035 With LFSR_CTRL_WORD_CNT_EN, 5 grants -> word_cnt=5; without it, word_cnt=0 throughout.
